perf_csr_snapshot: RTL
======================

// Module: perf_csr_snapshot
// PURPOSE
//  Software-facing reader for the performance monitor's latched counters.
//  - Captures all six counts into a shadow bank on each measurement_done pulse.
//  - Serves them through a valid/ready CSR read channel with a 1-cycle response latency.
//  - Holds a captured set stable until software acknowledges it, so the counters read
//    back always belong to the same run; flags runs that arrive before the acknowledge.
//  - Sits between perf and the CSR interconnect.
// PARAMETERS
//  COUNTER_WIDTH  32            width of every counter and of rd_data
//  SEQ_WIDTH      8             width of the snapshot sequence counter (must be <= 8)
//  BLOCK_ID       32'h50455246  constant returned at address 0x7
// PORTS
//  clk                 in   1    clock
//  rst_n               in   1    reset, asynchronous, active-low
//  measurement_done    in   1    1-cycle pulse; counts below valid in that cycle
//  total_cycles_in     in   CW   total cycles of the finished run
//  active_cycles_in    in   CW   busy cycles
//  idle_cycles_in      in   CW   non-busy cycles
//  cache_hit_in        in   CW   metadata cache hits
//  cache_miss_in       in   CW   metadata cache misses
//  decode_in           in   CW   metadata decode count
//  rd_req_valid        in   1    read request valid
//  rd_req_ready        out  1    read request accepted when valid&ready
//  rd_addr             in   4    word address
//  rd_resp_valid       out  1    response valid
//  rd_resp_ready       in   1    response consumed when valid&ready
//  rd_data             out  CW   response data
//  rd_err              out  1    address not mapped
//  wr_valid            in   1    1-cycle write strobe, always accepted
//  wr_addr             in   4    write address; only 0x0 is writable
//  wr_data             in   CW   write data (STATUS W1C bits)
//  snap_pending        out  1    copy of STATUS.valid, used as an interrupt source
// BEHAVIOUR
//  Register map:
//  - 0x0 STATUS: [0] valid, [1] overrun, [15:8] seq, other bits 0.
//  - 0x1 TOTAL, 0x2 ACTIVE, 0x3 IDLE, 0x4 HIT, 0x5 MISS, 0x6 DECODE.
//  - 0x7 BLOCK_ID.
//  - 0x8-0xF: rd_err=1, rd_data=0.
//  Reset values:
//  - Shadow bank, valid, overrun, seq and rd_data are 0.
//  - rd_resp_valid=0, rd_err=0, rd_req_ready=1.
//  Capture (evaluated on measurement_done):
//  - seq increments on every measurement_done, mod 2^SEQ_WIDTH; 0xFF wraps to 0x00.
//  - If valid_eff=0: load all six shadows from the inputs and set valid=1.
//  - If valid_eff=1: shadows unchanged and overrun set to 1.
//  - valid_eff = valid & ~(STATUS write this cycle with wr_data[0]=1).
//  Status writes:
//  - A write to 0x0 with bit0=1 clears valid; with bit1=1 clears overrun.
//  - Writes to any other address are ignored.
//  Simultaneous events:
//  - W1C of valid plus measurement_done in the same cycle: the capture is taken,
//    valid ends at 1, overrun is unchanged.
//  - W1C of overrun plus a dropped capture in the same cycle: overrun ends at 1
//    (set wins).
//  Read FSM:
//  - R_IDLE: rd_req_ready=1. On rd_req_valid, register rd_data/rd_err from the
//    current (pre-edge) state, then go to R_RESP.
//  - R_RESP: rd_req_ready=0, rd_resp_valid=1, rd_data/rd_err held stable.
//    On rd_resp_ready, return to R_IDLE. Back-to-back reads give at most 1 response
//    per 2 cycles.
//  - Latency: the response is valid in the cycle after the request is accepted.
//  - A capture in the same cycle as request acceptance returns the old shadow value.
//  - A capture during R_RESP does not alter the held rd_data.
//  Reset mid-operation: all state returns to reset values immediately (asynchronous);
//  any pending response is dropped.
// TESTING
//  - Reset, then read 0x7 -> rd_data=0x50455246, rd_err=0, rd_resp_valid exactly
//    1 cycle after accept.
//  - Pulse done with total=100, active=90, idle=10, hit=5, miss=2, decode=7.
//    Read 0x0 -> 0x00000101. Reads 0x1..0x6 -> 100, 90, 10, 5, 2, 7.
//  - Capture 100, then pulse done again with total=200 and no acknowledge.
//    Read 0x1 -> 100. STATUS -> 0x00000203.
//  - Write 0x0 data 0x3 in the same cycle as done with total=300.
//    STATUS -> 0x00000301 (valid=1, overrun=0). Read 0x1 -> 300.
//  - Request 0x2 with rd_resp_ready held low for 5 cycles while a capture occurs.
//    rd_data stays at the old value, rd_req_ready=0 throughout.
//    Read 0xA -> rd_err=1, rd_data=0.
//  - 256 done pulses -> seq wraps to 0x00. Assert rst_n low during R_RESP ->
//    rd_resp_valid=0 and STATUS=0 after release.

Source files
------------

// File: rtl/perf_csr_snapshot_if.sv
// CSR read/write channel between the performance snapshot block and the interconnect.
interface perf_csr_snapshot_if #(
  parameter int unsigned CW = 32
);
  localparam int unsigned AW = 4;

  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_resp_valid;
  logic          rd_resp_ready;
  logic [CW-1:0] rd_data;
  logic          rd_err;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;

  modport master (
    output rd_req_valid, rd_addr, rd_resp_ready, wr_valid, wr_addr, wr_data,
    input  rd_req_ready, rd_resp_valid, rd_data, rd_err
  );

  modport slave (
    input  rd_req_valid, rd_addr, rd_resp_ready, wr_valid, wr_addr, wr_data,
    output rd_req_ready, rd_resp_valid, rd_data, rd_err
  );
endinterface

// File: rtl/perf_csr_snapshot.sv
// Shadow bank for the perf monitor counters, read through a 1-deep valid/ready CSR channel.
// A captured set stays frozen until software W1C-clears STATUS.valid; later runs flag overrun.
module perf_csr_snapshot #(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned SEQ_WIDTH     = 8,
  parameter logic [31:0] BLOCK_ID      = 32'h50455246
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     measurement_done,
  input  logic [COUNTER_WIDTH-1:0] total_cycles_in,
  input  logic [COUNTER_WIDTH-1:0] active_cycles_in,
  input  logic [COUNTER_WIDTH-1:0] idle_cycles_in,
  input  logic [COUNTER_WIDTH-1:0] cache_hit_in,
  input  logic [COUNTER_WIDTH-1:0] cache_miss_in,
  input  logic [COUNTER_WIDTH-1:0] decode_in,
  perf_csr_snapshot_if.slave       csr,
  output logic                     snap_pending
);

  localparam int unsigned CW      = COUNTER_WIDTH;
  localparam int unsigned NUM_CNT = 6;
  localparam int unsigned SEQ_LSB = 8;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_e;

  rstate_e                   state_q, state_d;
  logic [NUM_CNT-1:0][CW-1:0] shadow_q, shadow_d;
  logic [NUM_CNT-1:0][CW-1:0] counts_in;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic [SEQ_WIDTH-1:0]      seq_q, seq_d;
  logic [CW-1:0]             rd_data_q, rd_data_d;
  logic                      rd_err_q, rd_err_d;

  logic          status_wr;
  logic          clr_valid;
  logic          clr_overrun;
  logic          valid_eff;
  logic          req_accept;
  logic [CW-1:0] status_word;
  logic [CW-1:0] mux_data;
  logic          mux_err;
  logic          unused_wr_bits;

  assign counts_in = {decode_in, cache_miss_in, cache_hit_in,
                      idle_cycles_in, active_cycles_in, total_cycles_in};

  assign status_wr      = csr.wr_valid && (csr.wr_addr == 4'h0);
  assign clr_valid      = status_wr && csr.wr_data[0];
  assign clr_overrun    = status_wr && csr.wr_data[1];
  assign valid_eff      = valid_q && !clr_valid;
  assign unused_wr_bits = ^csr.wr_data[CW-1:2];

  // Capture: an acknowledge in the same cycle frees the bank for the incoming run.
  always_comb begin
    shadow_d  = shadow_q;
    valid_d   = valid_eff;
    overrun_d = overrun_q && !clr_overrun;
    seq_d     = seq_q;
    if (measurement_done) begin
      seq_d = seq_q + SEQ_WIDTH'(1);
      if (!valid_eff) begin
        shadow_d = counts_in;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    status_word                         = '0;
    status_word[0]                      = valid_q;
    status_word[1]                      = overrun_q;
    status_word[SEQ_LSB +: SEQ_WIDTH]   = seq_q;
  end

  always_comb begin
    mux_data = '0;
    mux_err  = 1'b0;
    case (csr.rd_addr)
      4'h0:    mux_data = status_word;
      4'h1:    mux_data = shadow_q[0];
      4'h2:    mux_data = shadow_q[1];
      4'h3:    mux_data = shadow_q[2];
      4'h4:    mux_data = shadow_q[3];
      4'h5:    mux_data = shadow_q[4];
      4'h6:    mux_data = shadow_q[5];
      4'h7:    mux_data = CW'(BLOCK_ID);
      default: mux_err  = 1'b1;
    endcase
  end

  // Read FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= R_IDLE;
    else        state_q <= state_d;
  end

  // Read FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:  if (csr.rd_req_valid)  state_d = R_RESP;
      R_RESP:  if (csr.rd_resp_ready) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  // Read FSM: outputs decoded straight from the state flop
  always_comb begin
    csr.rd_req_ready  = 1'b0;
    csr.rd_resp_valid = 1'b0;
    case (state_q)
      R_IDLE:  csr.rd_req_ready  = 1'b1;
      R_RESP:  csr.rd_resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign req_accept = (state_q == R_IDLE) && csr.rd_req_valid;

  // Response data is sampled from pre-edge state and held through the whole response.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    if (req_accept) begin
      rd_data_d = mux_data;
      rd_err_d  = mux_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      seq_q     <= '0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      seq_q     <= seq_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign csr.rd_data = rd_data_q;
  assign csr.rd_err  = rd_err_q;
  assign snap_pending = valid_q;

endmodule
